// File: rtl/scancode_frame_ctrl.sv
// PS/2 scan-code frame controller: prefix decode, key-event FIFO and partial-frame resync.
// Optional typematic (auto-repeat) make filtering is enabled by defining TYPEMATIC_FILTER_EN.
module scancode_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edge_found,
  input  logic       valid_scan_code,
  input  logic [7:0] scan_code_in,
  output logic       conv_rst,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       overflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } key_event_t;

  state_t     state, state_next;
  key_event_t new_evt;
  logic       push_req, repeat_make, push, pop, push_ok, full, timeout;
  logic       is_e0, is_f0;

  logic [3:0]    edge_cnt;
  logic [CW-1:0] idle_cnt;

  key_event_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  key_event_t    head;

  assign is_e0 = (scan_code_in == 8'hE0);
  assign is_f0 = (scan_code_in == 8'hF0);

  // A frame is partial when 1..10 edges were seen; an edge this cycle keeps it alive.
  assign timeout  = (idle_cnt == CW'(TIMEOUT_CYCLES)) && (edge_cnt != 4'd0) && !edge_found;
  assign conv_rst = timeout;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    if (valid_scan_code) begin
      if (is_e0) begin
        if (state == IDLE) state_next = EXT;
      end else if (is_f0) begin
        if (state == IDLE)     state_next = BRK;
        else if (state == EXT) state_next = EXT_BRK;
      end else begin
        state_next = IDLE;
      end
    end
    // The byte above is decoded first; a coincident timeout still forces IDLE.
    if (timeout) state_next = IDLE;
  end

  always_comb begin
    new_evt.code = scan_code_in;
    new_evt.ext  = (state == EXT) || (state == EXT_BRK);
    new_evt.brk  = (state == BRK) || (state == EXT_BRK);
    push_req     = valid_scan_code && !is_e0 && !is_f0;
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       rec_valid;
  logic [8:0] rec;

  assign repeat_make = rec_valid && !new_evt.brk && (rec == {new_evt.code, new_evt.ext});

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_valid <= 1'b0;
      rec       <= '0;
    end else if (push_req) begin
      if (new_evt.brk) begin
        if (rec == {new_evt.code, new_evt.ext}) rec_valid <= 1'b0;
      end else if (push_ok) begin
        rec_valid <= 1'b1;
        rec       <= {new_evt.code, new_evt.ext};
      end
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  assign push      = push_req && !repeat_make;
  assign key_valid = (count != '0);
  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign push_ok   = push && (!full || pop);
  assign head      = mem[rd_ptr];

  assign key_code  = key_valid ? head.code : 8'h00;
  assign key_ext   = key_valid && head.ext;
  assign key_break = key_valid && head.brk;

  // NOTE: storage is not reset; count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= new_evt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt <= 4'd0;
      idle_cnt <= '0;
    end else begin
      if (timeout)                edge_cnt <= 4'd0;
      else if (edge_found)        edge_cnt <= (edge_cnt == 4'd10) ? 4'd0 : edge_cnt + 4'd1;

      if (edge_found)                         idle_cnt <= '0;
      else if (idle_cnt != CW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + CW'(1);
    end
  end

endmodule

// File: doc/scancode_frame_ctrl.md
SCANCODE_FRAME_CTRL -- requirements
Module: scancode_frame_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200000: idle clk cycles after a partial frame before resync.
REQ-002 Parameter FIFO_DEPTH, default 4: key-event FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 edge_found  input  1  one-cycle pulse per falling edge of the keyboard clock.
REQ-006 valid_scan_code  input  1  one-cycle pulse; scan_code_in holds a complete byte.
REQ-007 scan_code_in  input  8  byte from the serial-to-parallel converter.
REQ-008 conv_rst  output  1  one-cycle resync pulse to the converter.
REQ-009 key_valid  output  1  FIFO head holds a key event.
REQ-010 key_ready  input  1  consumer accepts the head event when key_valid and key_ready are both high.
REQ-011 key_code  output  8  final (non-prefix) scan code of the head event.
REQ-012 key_ext  output  1  head event was prefixed by E0.
REQ-013 key_break  output  1  head event was a release (prefixed by F0).
REQ-014 overflow  output  1  sticky: an event was dropped because the FIFO was full.

Function
REQ-015 Decode FSM states shall be IDLE, EXT, BRK and EXT_BRK.
REQ-016 On valid_scan_code with byte E0 in IDLE, the FSM shall move to EXT.
REQ-017 On valid_scan_code with byte F0, the FSM shall move IDLE->BRK and EXT->EXT_BRK.
REQ-018 On any other byte, the FSM shall form event {code, ext = (EXT or EXT_BRK), break = (BRK or EXT_BRK)}, push it and return to IDLE.
REQ-019 An E0 byte in a state other than IDLE, or an F0 byte in BRK or EXT_BRK, shall leave the state unchanged and push no event.
REQ-020 The pushed event shall be visible on key_* the cycle after valid_scan_code when the FIFO was empty (latency 1).
REQ-021 key_code, key_ext and key_break shall be 0 whenever key_valid is 0.
REQ-022 A push when full and without a simultaneous pop shall drop the new event and set overflow.
REQ-023 A push and a pop in the same cycle shall be allowed at any fill level, including full.
REQ-024 The FIFO shall be first-in first-out with pointer wrap-around modulo FIFO_DEPTH.
REQ-025 An edge counter shall increment on edge_found and clear to 0 after the 11th edge of a frame.
REQ-026 An idle counter shall clear on edge_found and otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-027 When the idle counter reaches TIMEOUT_CYCLES while the edge count is 1 to 10, the block shall:
 - pulse conv_rst for exactly one cycle;
 - clear the edge counter;
 - return the FSM to IDLE.
REQ-028 A timeout shall not flush the FIFO and shall not fire again until a new partial frame occurs.
REQ-029 If valid_scan_code coincides with a timeout, the byte shall be processed first; the timeout shall then return the FSM to IDLE.

Reset
REQ-030 On rst, the following shall clear within one cycle:
 - outputs: key_valid, key_code, key_ext, key_break, overflow and conv_rst to 0;
 - FSM to IDLE;
 - FIFO pointers and both counters to 0.
REQ-031 A rst mid-prefix (FSM in EXT, BRK or EXT_BRK) shall discard the prefix; the next non-prefix byte shall decode as a plain make.

Configuration
REQ-032 Macro TYPEMATIC_FILTER_EN shall enable typematic filtering when defined.
REQ-033 With TYPEMATIC_FILTER_EN defined, the block shall record the {code, ext} of the last make pushed.
REQ-034 With TYPEMATIC_FILTER_EN defined, a make equal to that record shall not be pushed.
REQ-035 With TYPEMATIC_FILTER_EN defined, a break matching the record, or a rst, shall clear the record.
REQ-036 Without TYPEMATIC_FILTER_EN, every make shall be pushed.

Verification
REQ-037 Bench scenario, bytes 1C: 1C -> one event {1C, ext 0, break 0}.
REQ-038 Bench scenario, bytes E0 F0 75: E0 F0 75 -> one event {75, ext 1, break 1}.
REQ-039 Bench scenario, FIFO fill: key_ready low, bytes 15 16 1E 26 2E -> four events held, then overflow=1; raising key_ready drains 15, 16, 1E, 26 in order.
REQ-040 Bench scenario, partial-frame timeout: 5 edge_found pulses, then TIMEOUT_CYCLES idle cycles -> one conv_rst pulse; no further pulse while idle.
REQ-041 Bench scenario, reset mid-prefix: F0, then rst, then 1C -> single event {1C, ext 0, break 0}.
REQ-042 Bench scenario, typematic filter with TYPEMATIC_FILTER_EN defined: 1C 1C 1C F0 1C 1C -> three events {1C make}, {1C break}, {1C make}; without the macro -> five events.
